// File: rtl/ext_link_rx.sv
// ext_link_rx: inter-board serial receiver (start + LSB-first data + stop) with ack pulse and valid/ready output.
// Optional even-parity bit and parity_err port when EXT_RX_PARITY_EN is defined.
module ext_link_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int ACK_BITS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  receiver_en,
    input  logic                  ext_data_in,
    output logic                  ack_out,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
`ifdef EXT_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic [2:0]            state_rx
);

    localparam int ACK_LEN = ACK_BITS * CLKS_PER_BIT;
    localparam int BW      = $clog2(CLKS_PER_BIT);
    localparam int AW      = $clog2(ACK_LEN);
    localparam int CW      = $clog2(DATA_WIDTH + 1);

    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        ACK    = 3'd4
`ifdef EXT_RX_PARITY_EN
        , PARITY = 3'd5
`endif
    } state_t;

    state_t                state;
    logic [1:0]            sync;
    logic                  en_d;
    logic [BW-1:0]         bit_cnt;
    logic [AW-1:0]         ack_cnt;
    logic [CW-1:0]         data_cnt;
    logic [DATA_WIDTH-1:0] shreg;

    logic sin;
    logic bit_done;
    logic en_fall;

    assign sin      = sync[1];
    assign bit_done = (bit_cnt == BIT_LAST);
    assign en_fall  = en_d & ~receiver_en;
    assign state_rx = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sync       <= '1;
            en_d       <= 1'b0;
            bit_cnt    <= '0;
            ack_cnt    <= '0;
            data_cnt   <= '0;
            shreg      <= '0;
            ack_out    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef EXT_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            sync <= {sync[0], ext_data_in};
            en_d <= receiver_en;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            // A falling enable forces IDLE below, so no flag can be set in the same cycle.
            if (en_fall) begin
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
`ifdef EXT_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!sin && receiver_en)
                        state <= START;
                end
                START: begin
                    if (!receiver_en) begin
                        state <= IDLE;
                    end else if (bit_cnt == HALF_LAST) begin
                        bit_cnt  <= '0;
                        data_cnt <= '0;
                        state    <= sin ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (!receiver_en) begin
                        state <= IDLE;
                    end else if (bit_done) begin
                        bit_cnt  <= '0;
                        shreg    <= {sin, shreg[DATA_WIDTH-1:1]};
                        data_cnt <= data_cnt + 1'b1;
                        if (data_cnt == DATA_LAST)
`ifdef EXT_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef EXT_RX_PARITY_EN
                PARITY: begin
                    if (!receiver_en) begin
                        state <= IDLE;
                    end else if (bit_done) begin
                        bit_cnt <= '0;
                        if (^{shreg, sin}) begin
                            parity_err <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (!receiver_en) begin
                        state <= IDLE;
                    end else if (bit_done) begin
                        bit_cnt <= '0;
                        if (sin) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_ready)
                                overrun <= 1'b1;
                            ack_out <= 1'b1;
                            ack_cnt <= '0;
                            state   <= ACK;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (ack_cnt == ACK_LAST) begin
                        ack_out <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
